spi_cmd_sequencer: RTL

Upstream feeder for the SPI master.
- Accepts SPI transactions (address, write data, rd_we) on a valid/ready command port and buffers them in a small FIFO.
- Launches each transaction in order via the master's enable/busy handshake, and captures read data on data_read_valid.
- Returns one response per command on a valid/ready response port, including a timeout error flag.

---
 rtl/spi_seq_pkg.sv | 18 +
 rtl/spi_cmd_fifo.sv | 60 ++++++
 rtl/spi_cmd_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared FSM encoding and command entry layout for the SPI command sequencer
package spi_seq_pkg;

  // Sequencer FSM states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_RESPOND   = 3'd4
  } seq_state_t;

  // A queued command is packed MSB-first as {address, rd_we, data}.
  function automatic int entry_width(input int address_width, input int data_width);
    return address_width + 1 + data_width;
  endfunction

endpackage

// File: rtl/spi_cmd_fifo.sv
// rtl/spi_cmd_fifo.sv - synchronous command FIFO with occupancy count, no write-to-read bypass
module spi_cmd_fifo #(
  parameter  int WIDTH   = 65,
  parameter  int DEPTH   = 4,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               push,
  input  logic [WIDTH-1:0]   push_data,
  input  logic               pop,
  output logic [WIDTH-1:0]   head_data,
  output logic [COUNT_W-1:0] count,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so the ready path never sees push.
  assign full      = (count == COUNT_W'(DEPTH));
  assign empty     = (count == '0);
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem[rd_ptr];

  // Storage array; written only on an accepted push, read as the registered head.
  always_ff @(posedge clock) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two; count tracks occupancy.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_W'(1);
        2'b01:   count <= count - COUNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - queues SPI commands, launches them on the master and returns one response each
module spi_cmd_sequencer
  import spi_seq_pkg::*;
#(
  parameter  int DATA_WIDTH     = 32,
  parameter  int ADDRESS_WIDTH  = 32,
  parameter  int FIFO_DEPTH     = 4,
  parameter  int TIMEOUT_CYCLES = 65535,
  localparam int COUNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ADDRESS_WIDTH-1:0] cmd_address,
  input  logic [DATA_WIDTH-1:0]    cmd_data,
  input  logic                     cmd_rd_we,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [DATA_WIDTH-1:0]    rsp_data,
  output logic                     rsp_rd_we,
  output logic                     rsp_error,
  output logic                     spi_enable,
  output logic [ADDRESS_WIDTH-1:0] spi_address,
  output logic [DATA_WIDTH-1:0]    spi_data,
  output logic                     spi_rd_we,
  input  logic                     spi_busy,
  input  logic [DATA_WIDTH-1:0]    spi_data_read,
  input  logic                     spi_data_read_valid,
  output logic [COUNT_W-1:0]       fifo_count,
  output logic                     seq_idle
);

  localparam int ENTRY_W = entry_width(ADDRESS_WIDTH, DATA_WIDTH);
  localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  seq_state_t state_q;
  seq_state_t state_d;

  logic [ENTRY_W-1:0]       push_entry;
  logic [ENTRY_W-1:0]       head_entry;
  logic [ADDRESS_WIDTH-1:0] head_address;
  logic [DATA_WIDTH-1:0]    head_data;
  logic                     head_rd_we;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic                     cmd_push;
  logic                     pop_req;

  logic                     sync_meta;
  logic                     sync_q;
  logic                     sync_q_d;
  logic                     valid_rise;

  logic [TIMER_W-1:0]       timer_q;
  logic [TIMER_W-1:0]       timer_d;
  logic [TIMER_W-1:0]       timer_inc;
  logic                     read_seen_q;
  logic                     read_seen_d;

  logic                     enable_d;
  logic [ADDRESS_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0]    data_d;
  logic                     rd_we_d;
  logic                     rsp_valid_d;
  logic [DATA_WIDTH-1:0]    rsp_data_d;
  logic                     rsp_rd_we_d;
  logic                     rsp_error_d;

  assign cmd_ready    = !fifo_full;
  assign cmd_push     = cmd_valid && cmd_ready;
  assign push_entry   = {cmd_address, cmd_rd_we, cmd_data};
  assign head_address = head_entry[ENTRY_W-1 -: ADDRESS_WIDTH];
  assign head_rd_we   = head_entry[DATA_WIDTH];
  assign head_data    = head_entry[DATA_WIDTH-1:0];
  assign seq_idle     = fifo_empty && (state_q == ST_IDLE);
  assign valid_rise   = sync_q & ~sync_q_d;

  spi_cmd_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (cmd_push),
    .push_data (push_entry),
    .pop       (pop_req),
    .head_data (head_entry),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Two-flop synchronizer plus a delay stage for rising-edge detection of read valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      sync_q_d  <= 1'b0;
    end else begin
      sync_meta <= spi_data_read_valid;
      sync_q    <= sync_meta;
      sync_q_d  <= sync_q;
    end
  end

  // Next-state and next-output logic; every registered output holds unless a state updates it.
  always_comb begin
    state_d     = state_q;
    pop_req     = 1'b0;
    enable_d    = spi_enable;
    address_d   = spi_address;
    data_d      = spi_data;
    rd_we_d     = spi_rd_we;
    rsp_data_d  = rsp_data;
    rsp_rd_we_d = rsp_rd_we;
    rsp_error_d = rsp_error;
    timer_d     = timer_q;
    read_seen_d = read_seen_q;
    timer_inc   = (timer_q == '1) ? timer_q : timer_q + TIMER_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !spi_busy) begin
          pop_req     = 1'b1;
          address_d   = head_address;
          data_d      = head_data;
          rd_we_d     = head_rd_we;
          rsp_rd_we_d = head_rd_we;
          rsp_data_d  = '0;
          rsp_error_d = 1'b0;
          timer_d     = '0;
          read_seen_d = 1'b0;
          state_d     = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        timer_d = timer_inc;
        if (spi_busy) begin
          enable_d = 1'b0;
          state_d  = ST_WAIT_DONE;
        end else if (timer_q == TIMER_LAST) begin
          enable_d    = 1'b0;
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_DRAIN;
        end else begin
          enable_d = 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        timer_d  = timer_inc;
        enable_d = 1'b0;
        if (valid_rise && spi_rd_we) begin
          rsp_data_d  = spi_data_read;
          read_seen_d = 1'b1;
        end
        // A valid rise coinciding with busy falling still counts as a seen read.
        if (!spi_busy) begin
          rsp_error_d = spi_rd_we & ~(read_seen_q | valid_rise);
          state_d     = ST_RESPOND;
        end else if (timer_q == TIMER_LAST) begin
          rsp_error_d = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        enable_d = 1'b0;
        if (!spi_busy) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rsp_valid_d = (state_d == ST_RESPOND);
  end

  // State, master-side and response registers; reset drops any in-flight transaction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      spi_enable  <= 1'b0;
      spi_address <= '0;
      spi_data    <= '0;
      spi_rd_we   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_rd_we   <= 1'b0;
      rsp_error   <= 1'b0;
      timer_q     <= '0;
      read_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      spi_enable  <= enable_d;
      spi_address <= address_d;
      spi_data    <= data_d;
      spi_rd_we   <= rd_we_d;
      rsp_valid   <= rsp_valid_d;
      rsp_data    <= rsp_data_d;
      rsp_rd_we   <= rsp_rd_we_d;
      rsp_error   <= rsp_error_d;
      timer_q     <= timer_d;
      read_seen_q <= read_seen_d;
    end
  end

endmodule
